// File: rtl/dm_arbiter.sv
// Two-master round-robin arbiter for the single-port data memory, with burst cap and registered read return.
// Optional DM_ARB_PROT_EN: blocks M1 writes to the I/O words (addr >= IO_BASE) and flags them on m1_err.
module dm_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 32,
  parameter int BURST_MAX = 4,
  parameter int IO_BASE   = 29
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wd,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wd,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam int CW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state_reg;
  logic          rr_last_reg;
  logic [CW-1:0] beat_cnt_reg;

  logic own0;
  logic own1;
  logic owner_req;
  logic other_req;
  logic burst_cut;
  logic m1_blocked;

`ifdef DM_ARB_PROT_EN
  assign m1_blocked = (m1_addr >= AW'(IO_BASE));
`else
  // Protection disabled: the compare is kept only so IO_BASE stays referenced.
  assign m1_blocked = (m1_addr >= AW'(IO_BASE)) & 1'b0;
`endif

  assign own0      = (state_reg == OWN0);
  assign own1      = (state_reg == OWN1);
  assign m0_gnt    = own0 & m0_req;
  assign m1_gnt    = own1 & m1_req;
  assign owner_req = own0 ? m0_req : m1_req;
  assign other_req = own0 ? m1_req : m0_req;
  assign burst_cut = owner_req & other_req & (beat_cnt_reg == CNT_MAX);

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (own0) begin
      mem_we   = m0_we & m0_req;
      mem_addr = m0_addr;
      mem_wd   = m0_wd;
    end else if (own1) begin
      mem_we   = m1_we & m1_req & ~m1_blocked;
      mem_addr = m1_addr;
      mem_wd   = m1_wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      rr_last_reg  <= 1'b1;
      beat_cnt_reg <= '0;
      m0_rvalid    <= 1'b0;
      m1_rvalid    <= 1'b0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
      m1_err       <= 1'b0;
    end else begin
      m0_rvalid <= m0_gnt & ~m0_we;
      m1_rvalid <= m1_gnt & ~m1_we;
      if (m0_gnt & ~m0_we) m0_rdata <= mem_rd;
      if (m1_gnt & ~m1_we) m1_rdata <= mem_rd;
      m1_err <= m1_gnt & m1_we & m1_blocked;

      case (state_reg)
        IDLE: begin
          beat_cnt_reg <= '0;
          // rr_last names the master served most recently; on a tie the other one wins.
          if (m0_req && m1_req) state_reg <= rr_last_reg ? OWN0 : OWN1;
          else if (m0_req)      state_reg <= OWN0;
          else if (m1_req)      state_reg <= OWN1;
        end
        OWN0, OWN1: begin
          if (!owner_req) begin
            state_reg    <= other_req ? (own0 ? OWN1 : OWN0) : IDLE;
            beat_cnt_reg <= '0;
          end else begin
            rr_last_reg <= own1;
            if (burst_cut) begin
              state_reg    <= own0 ? OWN1 : OWN0;
              beat_cnt_reg <= '0;
            end else if (beat_cnt_reg != CNT_MAX) begin
              beat_cnt_reg <= beat_cnt_reg + CW'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: directed beats push expected read data, a monitor pops on rvalid.
// Covers reset, single-master traffic, burst alternation, bubbles, round-robin tie-break and I/O protection.
module tb_dm_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req [2];
  logic        we [2];
  logic [15:0] addr [2];
  logic [31:0] wd [2];
  logic        gnt [2];
  logic        rvalid [2];
  logic [31:0] rdata [2];
  logic        m1_err;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] dm [0:63];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  int vectors;
  int miscompares;
  int cyc;

  dm_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m0_req   (req[0]),
    .m0_we    (we[0]),
    .m0_addr  (addr[0]),
    .m0_wd    (wd[0]),
    .m0_gnt   (gnt[0]),
    .m0_rvalid(rvalid[0]),
    .m0_rdata (rdata[0]),
    .m1_req   (req[1]),
    .m1_we    (we[1]),
    .m1_addr  (addr[1]),
    .m1_wd    (wd[1]),
    .m1_gnt   (gnt[1]),
    .m1_rvalid(rvalid[1]),
    .m1_rdata (rdata[1]),
    .m1_err   (m1_err),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory environment: combinational read, write on posedge.
  assign mem_rd = dm[mem_addr[5:0]];
  always @(posedge clk) if (mem_we) dm[mem_addr[5:0]] <= mem_wd;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rvalid must match the oldest expected read of that master.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid[0]) begin
        if (q0.size() == 0) chk("m0 unexpected rvalid", 32'd1, 32'd0);
        else chk("m0 rdata", rdata[0], q0.pop_front());
      end
      if (rvalid[1]) begin
        if (q1.size() == 0) chk("m1 unexpected rvalid", 32'd1, 32'd0);
        else chk("m1 rdata", rdata[1], q1.pop_front());
      end
    end
  end

  // One beat: hold request until granted, check the memory side, push expected read data.
  task automatic beat(input int m, input logic w, input logic [15:0] a, input logic [31:0] d,
                      output int lat, output int gc);
    logic exp_we;
    lat = 0;
    gc  = -1;
    req[m] = 1'b1; we[m] = w; addr[m] = a; wd[m] = d;
    forever begin
      @(negedge clk);
      if (gnt[m]) break;
      lat++;
      if (lat > 40) begin
        chk("grant timeout", 32'd0, 32'd1);
        req[m] = 1'b0;
        return;
      end
    end
    gc = cyc;
    exp_we = w;
`ifdef DM_ARB_PROT_EN
    if (m == 1 && a >= 16'd29) exp_we = 1'b0;
`endif
    chk("mem_we on beat", 32'(mem_we), 32'(exp_we));
    chk("mem_addr on beat", 32'(mem_addr), 32'(a));
    if (w) chk("mem_wd on beat", mem_wd, d);
    else if (m == 0) q0.push_back(d);
    else q1.push_back(d);
    $display("beat m%0d %s addr=%0d data=%h cycle=%0d wait=%0d", m, w ? "wr" : "rd", a, d, gc, lat);
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " m0_gnt"}, 32'(gnt[0]), 32'd0);
    chk({tag, " m1_gnt"}, 32'(gnt[1]), 32'd0);
    chk({tag, " m0_rvalid"}, 32'(rvalid[0]), 32'd0);
    chk({tag, " m1_rvalid"}, 32'(rvalid[1]), 32'd0);
    chk({tag, " m0_rdata"}, rdata[0], 32'd0);
    chk({tag, " m1_rdata"}, rdata[1], 32'd0);
    chk({tag, " m1_err"}, 32'(m1_err), 32'd0);
    chk({tag, " mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, " mem_wd"}, mem_wd, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req[0] = 1'b0;
    req[1] = 1'b0;
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    req[0] = 1'b0;
    req[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int gc;
    int g0 [8];
    int g1 [8];
    int l0 [8];
    int l1 [8];
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    for (int i = 0; i < 64; i++) dm[i] = 32'hA5A5_0000 + 32'(i);
    for (int m = 0; m < 2; m++) begin
      req[m] = 1'b0; we[m] = 1'b0; addr[m] = '0; wd[m] = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_idle_outputs("reset");
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset asserted while a read response is pending.
    beat(0, 1'b0, 16'd3, 32'hA5A5_0003, lat, gc);
    chk("pre-reset rvalid", 32'(rvalid[0]), 32'd1);
    q0.delete();
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("async reset");
    req[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Both masters stream reads from reset: 4-beat bursts alternate, M0 first.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          beat(0, 1'b0, 16'(i), 32'hA5A5_0000 + 32'(i), l0[i], g0[i]);
        end
        req[0] = 1'b0;
      end
      begin
        for (int i = 0; i < 8; i++) begin
          beat(1, 1'b0, 16'(16 + i), 32'hA5A5_0010 + 32'(i), l1[i], g1[i]);
        end
        req[1] = 1'b0;
      end
    join
    chk("burst first grant latency", 32'(l0[0]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("burst m0 first run", 32'(g0[i]), 32'(g0[0] + i));
      chk("burst m1 first run", 32'(g1[i]), 32'(g0[0] + 4 + i));
      chk("burst m0 second run", 32'(g0[4 + i]), 32'(g0[0] + 8 + i));
      chk("burst m1 second run", 32'(g1[4 + i]), 32'(g0[0] + 12 + i));
    end
    gap();

    // M0 alone: write then read back.
    beat(0, 1'b1, 16'd5, 32'h1234_5678, lat, gc);
    chk("m0 write grant latency", 32'(lat), 32'd1);
    chk("m0 no rvalid after write", 32'(rvalid[0]), 32'd0);
    beat(0, 1'b0, 16'd5, 32'h1234_5678, lat, gc);
    chk("m0 read back-to-back", 32'(lat), 32'd0);
    gap();

    // M1 alone: 10 consecutive reads, no burst cut.
    for (int i = 0; i < 10; i++) begin
      beat(1, 1'b0, 16'(i), (i == 5) ? 32'h1234_5678 : 32'hA5A5_0000 + 32'(i), lat, gc);
      if (i == 0) g1[0] = gc;
      else chk("m1 stream consecutive", 32'(gc), 32'(g1[0] + i));
    end
    gap();

    // M0 stops after 2 beats with M1 waiting: one bubble, then M1.
    fork
      begin
        beat(0, 1'b0, 16'd1, 32'hA5A5_0001, l0[0], g0[0]);
        beat(0, 1'b0, 16'd2, 32'hA5A5_0002, l0[1], g0[1]);
        req[0] = 1'b0;
      end
      begin
        beat(1, 1'b0, 16'd7, 32'hA5A5_0007, l1[0], g1[0]);
        req[1] = 1'b0;
      end
    join
    chk("drop m0 second beat", 32'(g0[1]), 32'(g0[0] + 1));
    chk("drop m1 after bubble", 32'(g1[0]), 32'(g0[1] + 2));
    gap();
    beat(0, 1'b0, 16'd4, 32'hA5A5_0004, lat, gc);
    gap();
    // M0 served last, so a simultaneous request from idle favours M1.
    fork
      begin
        beat(0, 1'b0, 16'd8, 32'hA5A5_0008, l0[0], g0[0]);
        req[0] = 1'b0;
      end
      begin
        beat(1, 1'b0, 16'd9, 32'hA5A5_0009, l1[0], g1[0]);
        req[1] = 1'b0;
      end
    join
    chk("tie favours m1 latency", 32'(l1[0]), 32'd1);
    chk("tie m0 after bubble", 32'(g0[0]), 32'(g1[0] + 2));
    gap();

    // M1 writes an I/O word, then reads it back; M0 writes the same word.
    beat(1, 1'b1, 16'd30, 32'h0000_00FF, lat, gc);
    req[1] = 1'b0;
    @(negedge clk);
`ifdef DM_ARB_PROT_EN
    chk("m1_err after blocked write", 32'(m1_err), 32'd1);
    chk("led_1 unchanged", dm[30], 32'hA5A5_001E);
`else
    chk("m1_err stays low", 32'(m1_err), 32'd0);
    chk("led_1 written by m1", dm[30], 32'h0000_00FF);
`endif
    @(negedge clk);
    chk("m1_err pulse ends", 32'(m1_err), 32'd0);
    #1;
`ifdef DM_ARB_PROT_EN
    beat(1, 1'b0, 16'd30, 32'hA5A5_001E, lat, gc);
`else
    beat(1, 1'b0, 16'd30, 32'h0000_00FF, lat, gc);
`endif
    req[1] = 1'b0;
    gap();
    beat(0, 1'b1, 16'd30, 32'h0000_00FF, lat, gc);
    req[0] = 1'b0;
    @(negedge clk);
    chk("led_1 written by m0", dm[30], 32'h0000_00FF);
    chk("m1_err idle after m0 write", 32'(m1_err), 32'd0);
    gap();

    chk("m0 responses outstanding", 32'(q0.size()), 32'd0);
    chk("m1 responses outstanding", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
